// File: rtl/mem_arbiter_n.sv
// N-channel arbiter merging latched per-channel requests onto one single-beat memory bus.
// Fixed-priority (lowest index) or round-robin grant; one transaction outstanding at a time.
module mem_arbiter_n #(
    parameter int NCH = 2,
    parameter int RR  = 0,
    parameter int CW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_valid,
    input  logic [NCH-1:0]    ch_instr,
    input  logic [NCH*32-1:0] ch_addr,
    input  logic [NCH*32-1:0] ch_wdata,
    input  logic [NCH*4-1:0]  ch_wstrb,
    output logic [NCH-1:0]    ch_ready,
    output logic [31:0]       ch_rdata,
    output logic              memory_valid,
    output logic              memory_instr,
    output logic [31:0]       memory_addr,
    output logic [31:0]       memory_wdata,
    output logic [3:0]        memory_wstrb,
    input  logic [31:0]       memory_rdata,
    input  logic              memory_ready,
    output logic [CW-1:0]     memory_chan
);

    // Handshake: a channel pulses ch_valid for one cycle and is answered later by a one-cycle
    // ch_ready; the bus side holds memory_valid with a stable payload until memory_ready.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]     state;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] slot_instr;
    logic [31:0]    slot_addr  [NCH];
    logic [31:0]    slot_wdata [NCH];
    logic [3:0]     slot_wstrb [NCH];
    logic [CW-1:0]  ptr;
    logic [CW-1:0]  win;
    logic           win_found;
    logic           grant;

    // Winner selection works only on registered pend bits, so a same-cycle valid is not seen.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        if (RR == 0) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (pend[i]) win = CW'(i);
            end
        end else begin
            for (int k = 1; k <= NCH; k++) begin
                if (!win_found && pend[(int'(ptr) + k) % NCH]) begin
                    win       = CW'((int'(ptr) + k) % NCH);
                    win_found = 1'b1;
                end
            end
        end
    end

    assign grant = (|pend) && ((state == S_IDLE) || memory_ready);

    // Slot write beats slot clear, so a request landing on its own grant edge stays queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            slot_instr <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_addr[i]  <= '0;
                slot_wdata[i] <= '0;
                slot_wstrb[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i]) begin
                    pend[i]       <= 1'b1;
                    slot_instr[i] <= ch_instr[i];
                    slot_addr[i]  <= ch_addr[32*i +: 32];
                    slot_wdata[i] <= ch_wdata[32*i +: 32];
                    slot_wstrb[i] <= ch_wstrb[4*i +: 4];
                end else if (grant && (win == CW'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            ch_ready     <= '0;
            ch_rdata     <= '0;
            memory_valid <= 1'b0;
            memory_instr <= 1'b0;
            memory_addr  <= '0;
            memory_wdata <= '0;
            memory_wstrb <= '0;
            memory_chan  <= '0;
            ptr          <= '0;
        end else begin
            ch_ready <= '0;
            if ((state == S_BUSY) && memory_ready) begin
                ch_ready[memory_chan] <= 1'b1;
                ch_rdata              <= memory_rdata;
            end
            if (grant) begin
                state        <= S_BUSY;
                memory_valid <= 1'b1;
                memory_instr <= slot_instr[win];
                memory_addr  <= slot_addr[win];
                memory_wdata <= slot_wdata[win];
                memory_wstrb <= slot_wstrb[win];
                memory_chan  <= win;
                ptr          <= win;
            end else if ((state == S_BUSY) && memory_ready) begin
                state        <= S_IDLE;
                memory_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n: one fixed-priority and one round-robin instance (NCH=4)
// share the same stimulus; each check compares against hand-computed values.
module tb_mem_arbiter_n;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_valid;
    logic [3:0]   ch_instr;
    logic [127:0] ch_addr;
    logic [127:0] ch_wdata;
    logic [15:0]  ch_wstrb;
    logic [31:0]  memory_rdata;
    logic         memory_ready;

    logic [3:0]  fp_ch_ready, rr_ch_ready;
    logic [31:0] fp_ch_rdata, rr_ch_rdata;
    logic        fp_valid, rr_valid;
    logic        fp_instr, rr_instr;
    logic [31:0] fp_addr, rr_addr;
    logic [31:0] fp_wdata, rr_wdata;
    logic [3:0]  fp_wstrb, rr_wstrb;
    logic [1:0]  fp_chan, rr_chan;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];
    int rr_ord[5] = '{0, 1, 2, 3, 0};
    int fp_ord[5] = '{0, 1, 2, 0, 3};

    mem_arbiter_n #(.NCH(4), .RR(0)) u_fp (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_instr(ch_instr), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
        .ch_ready(fp_ch_ready), .ch_rdata(fp_ch_rdata),
        .memory_valid(fp_valid), .memory_instr(fp_instr), .memory_addr(fp_addr),
        .memory_wdata(fp_wdata), .memory_wstrb(fp_wstrb),
        .memory_rdata(memory_rdata), .memory_ready(memory_ready),
        .memory_chan(fp_chan)
    );

    mem_arbiter_n #(.NCH(4), .RR(1)) u_rr (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_instr(ch_instr), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
        .ch_ready(rr_ch_ready), .ch_rdata(rr_ch_rdata),
        .memory_valid(rr_valid), .memory_instr(rr_instr), .memory_addr(rr_addr),
        .memory_wdata(rr_wdata), .memory_wstrb(rr_wstrb),
        .memory_rdata(memory_rdata), .memory_ready(memory_ready),
        .memory_chan(rr_chan)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr);
        ch_valid[ch]           = 1'b1;
        ch_instr[ch]           = instr;
        ch_addr[ch*32 +: 32]   = addr;
        ch_wdata[ch*32 +: 32]  = wdata;
        ch_wstrb[ch*4 +: 4]    = wstrb;
    endtask

    task automatic drop_valid();
        ch_valid = '0;
    endtask

    // Scoreboard check
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_ch;
        rst          = 1'b1;
        ch_valid     = '0;
        ch_instr     = '0;
        ch_addr      = '0;
        ch_wdata     = '0;
        ch_wstrb     = '0;
        memory_rdata = '0;
        memory_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", 32'(fp_valid), 32'd0);
        chk("rst_ready", 32'(fp_ch_ready), 32'd0);
        chk("rst_rdata", fp_ch_rdata, 32'd0);
        chk("rst_addr", fp_addr, 32'd0);
        chk("rst_rr_valid", 32'(rr_valid), 32'd0);
        chk("rst_rr_chan", 32'(rr_chan), 32'd0);
        rst = 1'b0;
        tick();

        // Single read: valid at t0+2, ready one cycle after memory_ready
        set_req(0, 32'h100, 32'h0, 4'h0, 1'b0);
        tick();
        drop_valid();
        chk("rd_not_yet", 32'(fp_valid), 32'd0);
        tick();
        chk("rd_valid", 32'(fp_valid), 32'd1);
        chk("rd_addr", fp_addr, 32'h100);
        chk("rd_chan", 32'(fp_chan), 32'd0);
        chk("rd_wstrb", 32'(fp_wstrb), 32'd0);
        memory_ready = 1'b1;
        memory_rdata = 32'hDEADBEEF;
        tick();
        memory_ready = 1'b0;
        chk("rd_ready", 32'(fp_ch_ready), 32'h1);
        chk("rd_rdata", fp_ch_rdata, 32'hDEADBEEF);
        chk("rd_idle", 32'(fp_valid), 32'd0);
        tick();
        chk("rd_ready_pulse", 32'(fp_ch_ready), 32'd0);

        // Fixed priority: all four at once, grant order 0..3 with the bus held high
        for (int i = 0; i < 4; i++) begin
            set_req(i, 32'h1000 + i * 16, 32'h0, 4'h0, 1'b0);
            exp_q.push_back(4'(i));
        end
        tick();
        drop_valid();
        tick();
        memory_ready = 1'b1;
        memory_rdata = 32'hA5A50000;
        for (int j = 0; j < 4; j++) begin
            exp_ch = exp_q.pop_front();
            chk("fp_order", 32'(fp_chan), 32'(exp_ch));
            chk("fp_bus_held", 32'(fp_valid), 32'd1);
            chk("fp_addr", fp_addr, 32'h1000 + 32'(exp_ch) * 16);
            if (j > 0) chk("fp_done", 32'(fp_ch_ready), 32'(1 << (j - 1)));
            tick();
        end
        memory_ready = 1'b0;
        chk("fp_last_ready", 32'(fp_ch_ready), 32'h8);
        chk("fp_last_rdata", fp_ch_rdata, 32'hA5A50000);
        chk("fp_end_idle", 32'(fp_valid), 32'd0);
        tick();

        // Round-robin vs fixed: ch0 re-requests after its ready while ch1..3 wait
        set_req(0, 32'h600, 32'h0, 4'h0, 1'b0);
        tick();
        drop_valid();
        for (int i = 1; i < 4; i++) set_req(i, 32'h600 + i * 4, 32'h0, 4'h0, 1'b0);
        tick();
        drop_valid();
        memory_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            chk("rr_order", 32'(rr_chan), 32'(rr_ord[j]));
            chk("rr_bus_held", 32'(rr_valid), 32'd1);
            chk("fp_starve_order", 32'(fp_chan), 32'(fp_ord[j]));
            if (j == 1) set_req(0, 32'h610, 32'h0, 4'h0, 1'b0);
            tick();
            drop_valid();
        end
        memory_ready = 1'b0;
        chk("rr_last_ready", 32'(rr_ch_ready), 32'h1);
        chk("fp_last_ready2", 32'(fp_ch_ready), 32'h8);
        chk("rr_end_idle", 32'(rr_valid), 32'd0);
        tick();

        // Overwrite: second pulse on ch1 replaces the first before grant
        set_req(0, 32'h300, 32'h0, 4'h0, 1'b0);
        tick();
        drop_valid();
        set_req(1, 32'h20, 32'h0, 4'h0, 1'b0);
        tick();
        drop_valid();
        chk("ow_first_chan", 32'(fp_chan), 32'd0);
        chk("ow_first_addr", fp_addr, 32'h300);
        set_req(1, 32'h24, 32'h0, 4'h0, 1'b0);
        tick();
        drop_valid();
        chk("ow_stable_addr", fp_addr, 32'h300);
        memory_ready = 1'b1;
        tick();
        chk("ow_chan", 32'(fp_chan), 32'd1);
        chk("ow_addr", fp_addr, 32'h24);
        chk("ow_rr_addr", rr_addr, 32'h24);
        chk("ow_ready0", 32'(fp_ch_ready), 32'h1);
        tick();
        memory_ready = 1'b0;
        chk("ow_ready1", 32'(fp_ch_ready), 32'h2);
        chk("ow_idle", 32'(fp_valid), 32'd0);
        tick();
        chk("ow_single_ready", 32'(fp_ch_ready), 32'd0);
        chk("ow_no_reissue", 32'(fp_valid), 32'd0);

        // Queue while in flight: ch0 write, second ch0 request issued back-to-back
        set_req(0, 32'h400, 32'h11111111, 4'hF, 1'b1);
        tick();
        drop_valid();
        tick();
        chk("q_valid", 32'(fp_valid), 32'd1);
        chk("q_wstrb", 32'(fp_wstrb), 32'hF);
        chk("q_wdata", fp_wdata, 32'h11111111);
        chk("q_instr", 32'(fp_instr), 32'd1);
        set_req(0, 32'h404, 32'h22222222, 4'h3, 1'b0);
        tick();
        drop_valid();
        chk("q_stable_addr", fp_addr, 32'h400);
        chk("q_stable_wstrb", 32'(fp_wstrb), 32'hF);
        memory_ready = 1'b1;
        memory_rdata = 32'hCAFE0001;
        tick();
        chk("q_ready1", 32'(fp_ch_ready), 32'h1);
        chk("q_rdata1", fp_ch_rdata, 32'hCAFE0001);
        chk("q_b2b_valid", 32'(fp_valid), 32'd1);
        chk("q_addr2", fp_addr, 32'h404);
        chk("q_wstrb2", 32'(fp_wstrb), 32'h3);
        chk("q_wdata2", fp_wdata, 32'h22222222);
        chk("q_instr2", 32'(fp_instr), 32'd0);
        memory_rdata = 32'hCAFE0002;
        tick();
        memory_ready = 1'b0;
        chk("q_ready2", 32'(fp_ch_ready), 32'h1);
        chk("q_rdata2", fp_ch_rdata, 32'hCAFE0002);
        chk("q_idle", 32'(fp_valid), 32'd0);
        tick();
        chk("q_ready_done", 32'(fp_ch_ready), 32'd0);

        // Reset mid-BUSY with a second request still pending
        set_req(0, 32'h500, 32'h0, 4'h0, 1'b0);
        set_req(1, 32'h504, 32'h0, 4'h0, 1'b0);
        tick();
        drop_valid();
        tick();
        chk("mr_busy", 32'(fp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_valid", 32'(fp_valid), 32'd0);
        chk("mr_addr", fp_addr, 32'd0);
        chk("mr_rdata", fp_ch_rdata, 32'd0);
        chk("mr_rr_valid", 32'(rr_valid), 32'd0);
        memory_ready = 1'b1;
        tick();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("mr_no_ready", 32'(fp_ch_ready), 32'd0);
            chk("mr_no_issue", 32'(fp_valid), 32'd0);
            chk("mr_rr_no_issue", 32'(rr_valid), 32'd0);
        end
        memory_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
